// File: rtl/product_cursor_ctrl_pkg.sv
// rtl/product_cursor_ctrl_pkg.sv - shared grid constants, state codes, button priority and cursor helpers
// Purpose: constants and pure functions shared by the cursor controller, its
//          button conditioning and its bus interface.
// Ports:   none (package).
package product_cursor_ctrl_pkg;

   localparam int GRID_COLS    = 4;
   localparam int GRID_ROWS    = 3;
   localparam int NUM_PRODUCTS = GRID_COLS * GRID_ROWS;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BROWSE  = 2'd1;
   localparam logic [1:0] ST_CONFIRM = 2'd2;

   // Index of each button in the press vector; lower index wins.
   localparam int BTN_SELECT = 0;
   localparam int BTN_UP     = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 3;
   localparam int BTN_RIGHT  = 4;
   localparam int NUM_BTNS   = 5;

   typedef enum logic [2:0] {
      ACT_NONE   = 3'd0,
      ACT_SELECT = 3'd1,
      ACT_UP     = 3'd2,
      ACT_DOWN   = 3'd3,
      ACT_LEFT   = 3'd4,
      ACT_RIGHT  = 3'd5
   } action_t;

   // One action per cycle; simultaneous lower-priority presses are dropped.
   function automatic action_t pick_action(input logic [NUM_BTNS-1:0] press);
      action_t act;
      act = ACT_NONE;
      if (press[BTN_SELECT])     act = ACT_SELECT;
      else if (press[BTN_UP])    act = ACT_UP;
      else if (press[BTN_DOWN])  act = ACT_DOWN;
      else if (press[BTN_LEFT])  act = ACT_LEFT;
      else if (press[BTN_RIGHT]) act = ACT_RIGHT;
      return act;
   endfunction

   // Compare-based decode so an out-of-range index can never select a bit.
   function automatic logic [NUM_PRODUCTS-1:0] cell_onehot(input logic [3:0] idx);
      logic [NUM_PRODUCTS-1:0] oh;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         oh[i] = (idx == 4'(i));
      end
      return oh;
   endfunction

   // Row lives in idx[3:2] and column in idx[1:0] because the grid is 4 wide;
   // columns wrap through 2-bit overflow, rows wrap explicitly at 3.
   function automatic logic [3:0] move_cursor(input logic [3:0] cur, input action_t act);
      logic [1:0] row;
      logic [1:0] col;
      row = cur[3:2];
      col = cur[1:0];
      case (act)
         ACT_RIGHT: col = col + 2'd1;
         ACT_LEFT:  col = col - 2'd1;
         ACT_DOWN:  row = (row >= 2'(GRID_ROWS - 1)) ? 2'd0 : row + 2'd1;
         ACT_UP:    row = (row == 2'd0) ? 2'(GRID_ROWS - 1) : row - 2'd1;
         default:   ;
      endcase
      return {row, col};
   endfunction

endpackage

// File: rtl/product_cursor_ctrl_if.sv
// rtl/product_cursor_ctrl_if.sv - button/frame inputs and highlight outputs of the cursor controller
// Purpose: bundles the raw buttons, frame pulse and grid outputs.
// Ports:   master drives BtnUp/BtnDown/BtnLeft/BtnRight/BtnSelect and FrameStart,
//          reads HighlightedProductList, SelectedMask, CursorID, SelectPulse, SelectID;
//          slave is the controller side.
interface product_cursor_ctrl_if;
   import product_cursor_ctrl_pkg::*;

   logic                    BtnUp;
   logic                    BtnDown;
   logic                    BtnLeft;
   logic                    BtnRight;
   logic                    BtnSelect;
   logic                    FrameStart;
   logic [NUM_PRODUCTS-1:0] HighlightedProductList;
   logic [NUM_PRODUCTS-1:0] SelectedMask;
   logic [3:0]              CursorID;
   logic                    SelectPulse;
   logic [3:0]              SelectID;

   modport master (
      output BtnUp, BtnDown, BtnLeft, BtnRight, BtnSelect, FrameStart,
      input  HighlightedProductList, SelectedMask, CursorID, SelectPulse, SelectID
   );

   modport slave (
      input  BtnUp, BtnDown, BtnLeft, BtnRight, BtnSelect, FrameStart,
      output HighlightedProductList, SelectedMask, CursorID, SelectPulse, SelectID
   );
endinterface

// File: rtl/product_cursor_ctrl_btn_debounce.sv
// rtl/product_cursor_ctrl_btn_debounce.sv - synchronizer, debounce counter and press pulse for one button
// Purpose: turns a raw asynchronous button into a one-cycle press on each
//          accepted rising edge of its debounced level; holding gives no repeat.
// Ports:   clk, rst_n (async active-low), raw (async button), press (one-cycle pulse).
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          sync3;
   logic          db_level;
   logic [CW-1:0] cnt;
   logic          stable;

   assign stable = (cnt == CW'(DEBOUNCE_CYCLES));

   // sync3 is the previous synchronized sample; cnt counts cycles since it
   // last changed, so the level is trusted only after a full quiet window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         cnt      <= '0;
         db_level <= 1'b0;
         press    <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         sync3 <= sync2;
         if (sync2 != sync3) begin
            cnt <= '0;
         end else if (!stable) begin
            cnt <= cnt + CW'(1);
         end
         if (stable) begin
            db_level <= sync3;
         end
         press <= stable & sync3 & ~db_level;
      end
   end
endmodule

// File: rtl/product_cursor_ctrl.sv
// rtl/product_cursor_ctrl.sv - product-grid cursor, selection mask and frame-aligned highlight
// Purpose: debounces five buttons, runs the IDLE/BROWSE/CONFIRM sequencer,
//          moves a wrapping cursor over the 4x3 grid, toggles selections and
//          latches the highlight list only on FrameStart.
// Ports:   clk, rst_n (async active-low), bus (slave modport: buttons,
//          FrameStart in; HighlightedProductList, SelectedMask, CursorID,
//          SelectPulse, SelectID out).
module product_cursor_ctrl
   import product_cursor_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int BLINK_FRAMES    = 30,
   parameter int CONFIRM_FRAMES  = 20,
   parameter int IDLE_FRAMES     = 1800
) (
   input logic                 clk,
   input logic                 rst_n,
   product_cursor_ctrl_if.slave bus
);
   localparam int BFW = $clog2(BLINK_FRAMES + 1);
   localparam int CFW = $clog2(CONFIRM_FRAMES + 1);
   localparam int IFW = $clog2(IDLE_FRAMES + 1);

   logic [NUM_BTNS-1:0]     raw;
   logic [NUM_BTNS-1:0]     press;
   action_t                 act;

   logic [1:0]              state;
   logic [3:0]              cursor;
   logic [NUM_PRODUCTS-1:0] mask;
   logic [NUM_PRODUCTS-1:0] hl;
   logic [NUM_PRODUCTS-1:0] hl_next;
   logic                    sel_pulse;
   logic [3:0]              sel_id;
   logic                    blink_on;
   logic                    cursor_visible;
   logic [BFW-1:0]          blink_cnt;
   logic [CFW-1:0]          confirm_cnt;
   logic [IFW-1:0]          idle_cnt;

   assign raw[BTN_SELECT] = bus.BtnSelect;
   assign raw[BTN_UP]     = bus.BtnUp;
   assign raw[BTN_DOWN]   = bus.BtnDown;
   assign raw[BTN_LEFT]   = bus.BtnLeft;
   assign raw[BTN_RIGHT]  = bus.BtnRight;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (raw[i]),
         .press(press[i])
      );
   end

   assign act = pick_action(press);

   assign cursor_visible = (state == ST_CONFIRM) || ((state == ST_BROWSE) && blink_on);
   assign hl_next        = mask | (cursor_visible ? cell_onehot(cursor) : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cursor      <= 4'd0;
         mask        <= '0;
         hl          <= '0;
         sel_pulse   <= 1'b0;
         sel_id      <= 4'd0;
         blink_on    <= 1'b1;
         blink_cnt   <= '0;
         confirm_cnt <= '0;
         idle_cnt    <= '0;
      end else begin
         sel_pulse <= 1'b0;
         // hl_next is built from pre-update registers, so a move landing on
         // the FrameStart cycle shows up one frame later.
         if (bus.FrameStart) begin
            hl <= hl_next;
         end
         case (state)
            ST_IDLE: begin
               if (act != ACT_NONE) begin
                  state     <= ST_BROWSE;
                  blink_on  <= 1'b1;
                  blink_cnt <= '0;
                  idle_cnt  <= '0;
               end
            end
            ST_BROWSE: begin
               if (act == ACT_SELECT) begin
                  mask        <= mask ^ cell_onehot(cursor);
                  sel_pulse   <= 1'b1;
                  sel_id      <= cursor;
                  state       <= ST_CONFIRM;
                  confirm_cnt <= '0;
                  idle_cnt    <= '0;
               end else if (act != ACT_NONE) begin
                  cursor    <= move_cursor(cursor, act);
                  blink_on  <= 1'b1;
                  blink_cnt <= '0;
                  idle_cnt  <= '0;
               end else if (bus.FrameStart) begin
                  if (blink_cnt == BFW'(BLINK_FRAMES - 1)) begin
                     blink_cnt <= '0;
                     blink_on  <= ~blink_on;
                  end else begin
                     blink_cnt <= blink_cnt + BFW'(1);
                  end
                  if (idle_cnt == IFW'(IDLE_FRAMES - 1)) begin
                     idle_cnt <= '0;
                     state    <= ST_IDLE;
                  end else begin
                     idle_cnt <= idle_cnt + IFW'(1);
                  end
               end
            end
            ST_CONFIRM: begin
               // Presses are ignored here; only frames advance the hold.
               if (bus.FrameStart) begin
                  if (confirm_cnt == CFW'(CONFIRM_FRAMES - 1)) begin
                     confirm_cnt <= '0;
                     state       <= ST_BROWSE;
                     blink_on    <= 1'b1;
                     blink_cnt   <= '0;
                     idle_cnt    <= '0;
                  end else begin
                     confirm_cnt <= confirm_cnt + CFW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.HighlightedProductList = hl;
   assign bus.SelectedMask           = mask;
   assign bus.CursorID               = cursor;
   assign bus.SelectPulse            = sel_pulse;
   assign bus.SelectID               = sel_id;
endmodule

// File: tb/tb_product_cursor_ctrl.sv
// tb/tb_product_cursor_ctrl.sv - directed self-checking bench for product_cursor_ctrl
module tb_product_cursor_ctrl;
   localparam int DC   = 8;
   localparam int HOLD = DC + 12;

   localparam logic [4:0] B_SEL   = 5'b10000;
   localparam logic [4:0] B_UP    = 5'b01000;
   localparam logic [4:0] B_DOWN  = 5'b00100;
   localparam logic [4:0] B_LEFT  = 5'b00010;
   localparam logic [4:0] B_RIGHT = 5'b00001;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_q[$];
   logic prev_pulse = 1'b0;

   always #5 clk = ~clk;

   product_cursor_ctrl_if bus ();

   product_cursor_ctrl #(
      .DEBOUNCE_CYCLES(DC),
      .BLINK_FRAMES   (6),
      .CONFIRM_FRAMES (20),
      .IDLE_FRAMES    (40)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; every SelectPulse seen is matched against the scoreboard.
   task automatic cyc();
      int e;
      @(negedge clk);
      if (bus.SelectPulse === 1'b1) begin
         n_checks++;
         assert (exp_q.size() > 0 && !prev_pulse) else begin
            n_fail++;
            $error("FAIL select_pulse_unexpected observed=1 expected=0 (queued=%0d)", exp_q.size());
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("select_id", 16'(bus.SelectID), 16'(e));
         end
      end
      prev_pulse = bus.SelectPulse;
   endtask

   task automatic set_btns(input logic [4:0] m);
      bus.BtnSelect = m[4];
      bus.BtnUp     = m[3];
      bus.BtnDown   = m[2];
      bus.BtnLeft   = m[1];
      bus.BtnRight  = m[0];
   endtask

   task automatic press(input logic [4:0] m);
      set_btns(m);
      repeat (HOLD) cyc();
      set_btns(5'b0);
      repeat (HOLD) cyc();
   endtask

   task automatic bounce(input logic [4:0] m, input int n);
      set_btns(m);
      repeat (n) cyc();
      set_btns(5'b0);
      repeat (HOLD) cyc();
   endtask

   task automatic select(input logic [4:0] m, input int id);
      exp_q.push_back(id);
      press(m);
      chk("select_seen_queue_left", 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         bus.FrameStart = 1'b1;
         cyc();
         bus.FrameStart = 1'b0;
         cyc();
         cyc();
      end
   endtask

   task automatic chk_cursor(input string tag, input int exp);
      chk(tag, 16'(bus.CursorID), 16'(exp));
   endtask

   initial begin
      rst_n = 1'b0;
      set_btns(5'b0);
      bus.FrameStart = 1'b0;
      repeat (3) cyc();
      chk("rst_hl", 16'(bus.HighlightedProductList), 16'h000);
      chk("rst_mask", 16'(bus.SelectedMask), 16'h000);
      chk_cursor("rst_cursor", 0);
      chk("rst_pulse", 16'(bus.SelectPulse), 16'd0);
      chk("rst_selid", 16'(bus.SelectID), 16'd0);
      rst_n = 1'b1;
      frames(3);
      chk("idle_hl", 16'(bus.HighlightedProductList), 16'h000);
      chk_cursor("idle_cursor", 0);

      press(B_RIGHT);
      chk_cursor("idle_press_consumed", 0);
      press(B_RIGHT);
      chk_cursor("browse_right", 1);
      frames(1);
      chk("hl_cursor1", 16'(bus.HighlightedProductList), 16'h002);

      press(B_RIGHT);
      press(B_RIGHT);
      chk_cursor("right_to_3", 3);
      press(B_RIGHT);
      chk_cursor("wrap_right_3_to_0", 0);
      press(B_RIGHT);
      press(B_UP);
      chk_cursor("wrap_up_1_to_9", 9);
      press(B_RIGHT);
      press(B_RIGHT);
      chk_cursor("right_to_11", 11);
      press(B_DOWN);
      chk_cursor("wrap_down_11_to_3", 3);

      frames(6);
      chk("blink_on_last", 16'(bus.HighlightedProductList), 16'h008);
      frames(1);
      chk("blink_off", 16'(bus.HighlightedProductList), 16'h000);

      press(B_DOWN);
      chk_cursor("down_3_to_7", 7);
      press(B_RIGHT);
      chk_cursor("wrap_right_7_to_4", 4);
      press(B_RIGHT);
      chk_cursor("right_to_5", 5);

      select(B_SEL, 5);
      chk("mask_after_sel5", 16'(bus.SelectedMask), 16'h020);
      chk_cursor("cursor_after_sel", 5);
      press(B_LEFT);
      chk_cursor("confirm_ignore_left", 5);
      frames(19);
      chk("confirm_hl_solid", 16'(bus.HighlightedProductList), 16'h020);
      press(B_LEFT);
      chk_cursor("confirm_frame19_ignore", 5);
      frames(1);
      press(B_LEFT);
      chk_cursor("confirm_exit_left", 4);
      press(B_RIGHT);
      select(B_SEL, 5);
      chk("mask_after_resel5", 16'(bus.SelectedMask), 16'h000);
      frames(20);

      press(B_UP | B_RIGHT);
      chk_cursor("prio_up_over_right", 1);
      select(B_SEL | B_RIGHT, 1);
      chk_cursor("prio_sel_over_right", 1);
      chk("mask_after_sel1", 16'(bus.SelectedMask), 16'h002);
      frames(20);
      bounce(B_SEL, DC / 2);
      bounce(B_RIGHT, DC / 2);
      chk_cursor("bounce_no_move", 1);
      chk("bounce_no_toggle", 16'(bus.SelectedMask), 16'h002);

      frames(41);
      chk("idle_timeout_hl", 16'(bus.HighlightedProductList), 16'h002);
      press(B_RIGHT);
      chk_cursor("idle_timeout_consume", 1);
      press(B_RIGHT);
      chk_cursor("wake_right", 2);
      select(B_SEL, 2);
      chk("mask_after_sel2", 16'(bus.SelectedMask), 16'h006);
      frames(2);
      chk("confirm_hl", 16'(bus.HighlightedProductList), 16'h006);

      rst_n = 1'b0;
      #1;
      chk("midrst_hl", 16'(bus.HighlightedProductList), 16'h000);
      chk("midrst_mask", 16'(bus.SelectedMask), 16'h000);
      chk_cursor("midrst_cursor", 0);
      chk("midrst_pulse", 16'(bus.SelectPulse), 16'd0);
      chk("midrst_selid", 16'(bus.SelectID), 16'd0);
      set_btns(B_SEL);
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (2 * HOLD) cyc();
      set_btns(5'b0);
      repeat (HOLD) cyc();
      chk("postrst_mask", 16'(bus.SelectedMask), 16'h000);
      select(B_SEL, 0);
      chk("postrst_sel_mask", 16'(bus.SelectedMask), 16'h001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/product_cursor_ctrl.md
Name: product_cursor_ctrl

Overview:
Sequences the product-grid highlight for the sale-terminal display. Debounces five navigation buttons and moves a cursor over the 4x3 product grid. Keeps a selected-products mask and produces the one-hot HighlightedProductList consumed by the image locator. The highlight output updates only on frame boundaries, so no frame is drawn with a mid-frame change.

Parameters:
NUM_PRODUCTS, 12, number of grid cells (fixed to GRID_COLS*GRID_ROWS)
GRID_COLS, 4, cursor columns
GRID_ROWS, 3, cursor rows
DEBOUNCE_CYCLES, 250000, stable-level cycles required to accept a button edge (>=2)
BLINK_FRAMES, 30, frames per cursor blink half-period
CONFIRM_FRAMES, 20, frames the cursor is held solid after a select
IDLE_FRAMES, 1800, frames without a press before the cursor hides

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
BtnUp/BtnDown/BtnLeft/BtnRight/BtnSelect  in  1 each  raw, asynchronous, active-high buttons
FrameStart  in  1  one-cycle pulse at start of vertical blank, clk domain
HighlightedProductList  out  12  one-hot cursor bit OR'ed with SelectedMask, frame-aligned
SelectedMask  out  12  toggled-in products
CursorID  out  4  current cursor cell, 0..11, row-major
SelectPulse  out  1  one-cycle pulse on an accepted select
SelectID  out  4  cell index, valid while SelectPulse=1

Behaviour:
- Reset (rst_n=0, asynchronous) sets: state=IDLE, CursorID=0, SelectedMask=0, HighlightedProductList=0, SelectPulse=0, SelectID=0, all counters 0, synchronizers 0.
- Input conditioning, per button:
  - 2-FF synchronizer, then debounce counter.
  - The counter resets on any level change and saturates at DEBOUNCE_CYCLES.
  - A rising edge of the debounced level produces a one-cycle press. Holding a button gives no repeat.
- Simultaneous presses: one action per cycle. Priority is Select > Up > Down > Left > Right; lower-priority presses in the same cycle are dropped.
- Cursor arithmetic uses row=CursorID/4 and col=CursorID%4. Moves wrap within the grid:
  - Right at col 3 goes to col 0, same row. Left at col 0 goes to col 3.
  - Down at row 2 goes to row 0. Up at row 0 goes to row 2.
  - Example: Right from 7 gives 4; Up from 1 gives 9.
- States:
  - IDLE: cursor hidden. Any press goes to BROWSE and that press is consumed (cursor not moved, no select). Blink phase resets to ON.
  - BROWSE: Up/Down/Left/Right move the cursor and reset the blink phase to ON. Select toggles SelectedMask[CursorID], asserts SelectPulse with SelectID=CursorID the cycle after the debounced press, then goes to CONFIRM.
  - CONFIRM: cursor solid ON for CONFIRM_FRAMES FrameStart pulses, then returns to BROWSE. Presses during CONFIRM are ignored.
- Frame counters advance only on FrameStart:
  - Blink toggles every BLINK_FRAMES frames in BROWSE.
  - The idle counter clears on any accepted press. When it reaches IDLE_FRAMES in BROWSE, go to IDLE.
- Highlight shadow:
  - next = SelectedMask OR (cursor_visible ? onehot(CursorID) : 0).
  - Latched into HighlightedProductList only on the FrameStart cycle, so latency is at most one frame.
  - If FrameStart coincides with a move, the pre-move value is latched.
- Counter and bit-select bounds: CursorID is never 12..15. SelectedMask bits 12..15 do not exist. A 4-bit index is used as a 12-bit bit-select only after range-safe decode.
- Reset mid-CONFIRM or mid-debounce discards everything; no SelectPulse is emitted after reset release until a new full debounce completes.

Decomposition:
- Shared package/header holds:
  - grid constants: NUM_PRODUCTS, GRID_COLS, GRID_ROWS
  - state encodings: ST_IDLE=2'd0, ST_BROWSE=2'd1, ST_CONFIRM=2'd2
  - button priority order
- One sub-module, btn_debounce (synchronizer, debounce counter, rising-edge press pulse), instantiated five times.
- FSM, cursor arithmetic and highlight shadow stay in product_cursor_ctrl.

Test Plan:
1. Reset, then 3 FrameStarts -> HighlightedProductList=12'h000, CursorID=0, state IDLE.
2. Right press (held > DEBOUNCE_CYCLES) from IDLE -> BROWSE, CursorID=0. Second Right -> CursorID=1. Next FrameStart with blink ON -> HighlightedProductList=12'h002.
3. Cursor at 3, Right -> CursorID=0. Cursor at 1, Up -> CursorID=9. Cursor at 11, Down -> CursorID=3.
4. Cursor 5, Select -> SelectPulse one cycle with SelectID=5, SelectedMask=12'h020. During 20 frames of CONFIRM a Left press gives CursorID still 5. Select again after CONFIRM -> mask 12'h000.
5. Select and Right debounce-complete on the same cycle -> only select acted on, CursorID unchanged. A bounce shorter than DEBOUNCE_CYCLES -> no action.
6. BROWSE with no presses for IDLE_FRAMES FrameStarts -> IDLE, highlight = SelectedMask only. rst_n low mid-CONFIRM -> all outputs 0 immediately.
